// File: rtl/mips_pkg.sv
// Shared write-back types and constants for the MIPS datapath.
package mips_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         REG_W    = 5;
    localparam int         DATA_W   = 32;

    typedef struct packed {
        logic              live;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_queue.sv
// Small FIFO of load results awaiting the register-file write port.
// Entries can be killed by destination register; killed entries stay queued until popped.
module wb_load_queue
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  wb_entry_t               pushEntry,
    input  logic                    pop,
    output wb_entry_t               headEntry,
    input  logic                    kill,
    input  logic [REG_W-1:0]        killReg,
    output logic [$clog2(DEPTH):0]  count,
    output logic [2**REG_W-1:0]     liveMask
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t                entries [DEPTH];
    logic      [PW-1:0]       headPtr;
    logic      [PW-1:0]       tailPtr;
    logic      [$clog2(DEPTH):0] countNext;

    always_comb begin
        countNext = count;
        unique case ({push, pop})
            2'b10:   countNext = count + 1'b1;
            2'b01:   countNext = count - 1'b1;
            default: countNext = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && entries[i].rd == killReg) begin
                    entries[i].live <= 1'b0;
                end
            end
            // Popped slots are marked dead so the live mask can scan every slot.
            if (pop) begin
                entries[headPtr].live <= 1'b0;
                headPtr               <= headPtr + 1'b1;
            end
            if (push) begin
                entries[tailPtr] <= pushEntry;
                tailPtr          <= tailPtr + 1'b1;
            end
            count <= countNext;
        end
    end

    assign headEntry = entries[headPtr];

    always_comb begin
        liveMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].live) begin
                liveMask[entries[i].rd] = 1'b1;
            end
        end
        liveMask[REG_ZERO] = 1'b0;
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Arbitrates the single register-file write port between the ALU result and
// handshaked load returns, buffering loads that lose arbitration.
module wb_write_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alu_valid,
    input  logic [AW-1:0]           alu_reg,
    input  logic [DW-1:0]           alu_data,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [AW-1:0]           ld_reg,
    input  logic [DW-1:0]           ld_data,
    output logic                    regWrite,
    output logic [AW-1:0]           writeReg,
    output logic [DW-1:0]           writeData,
    output logic [2**AW-1:0]        pending_mask,
    output logic [$clog2(DEPTH):0]  q_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          ldAccept;
    logic          qPush;
    logic          qPop;
    logic          qKill;
    wb_entry_t     pushEntry;
    wb_entry_t     headEntry;
    logic          wrEn;
    logic [AW-1:0] wrReg;
    logic [DW-1:0] wrData;

    assign ld_ready  = (q_count != CW'(DEPTH));
    assign ldAccept  = ld_valid & ld_ready;
    assign pushEntry = '{live: (ld_reg != REG_ZERO), rd: ld_reg, data: ld_data};

    always_comb begin
        qPush  = 1'b0;
        qPop   = 1'b0;
        qKill  = 1'b0;
        wrEn   = 1'b0;
        wrReg  = alu_reg;
        wrData = alu_data;
        if (alu_valid) begin
            wrEn  = (alu_reg != REG_ZERO);
            qKill = 1'b1;
            // A same-cycle load to the same register is older than the ALU result.
            qPush = ldAccept && (ld_reg != alu_reg);
        end else if (q_count != '0) begin
            qPop   = 1'b1;
            wrEn   = headEntry.live;
            wrReg  = headEntry.rd;
            wrData = headEntry.data;
            qPush  = ldAccept;
        end else if (ldAccept) begin
            wrEn   = (ld_reg != REG_ZERO);
            wrReg  = ld_reg;
            wrData = ld_data;
        end
    end

    wb_load_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (qPush),
        .pushEntry (pushEntry),
        .pop       (qPop),
        .headEntry (headEntry),
        .kill      (qKill),
        .killReg   (alu_reg),
        .count     (q_count),
        .liveMask  (pending_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else begin
            regWrite <= wrEn;
            if (wrEn) begin
                writeReg  <= wrReg;
                writeData <= wrData;
            end
        end
    end

endmodule
